// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared write-back source encodings and default datapath
//               widths for the pipeline back end.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

   localparam int DATA_W_DEF     = 16;
   localparam int REG_ADDR_W_DEF = 3;
   localparam int CNT_W_DEF      = 16;

   localparam logic [1:0] WB_SEL_ALU    = 2'b00;
   localparam logic [1:0] WB_SEL_MEM    = 2'b01;
   localparam logic [1:0] WB_SEL_IMM    = 2'b10;
   localparam logic [1:0] WB_SEL_INPORT = 2'b11;

endpackage
`default_nettype wire

// File: rtl/exm_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : exm_wb_buffer
// Description : EXM/WB pipeline register. Priority reset > flush > stall >
//               load; flush inserts an all-zero bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module exm_wb_buffer
   import pipeline_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic                  i_valid,
   input  logic [1:0]            i_wb_selector,
   input  logic                  i_write_back,
   input  logic [REG_ADDR_W-1:0] i_write_addr,
   input  logic [DATA_W-1:0]     i_ex_result,
   input  logic [DATA_W-1:0]     i_memory_data,
   input  logic [DATA_W-1:0]     i_immediate,
   input  logic [DATA_W-1:0]     i_in_port,
   output logic                  o_valid,
   output logic [1:0]            o_wb_selector,
   output logic                  o_write_back,
   output logic [REG_ADDR_W-1:0] o_write_addr,
   output logic [DATA_W-1:0]     o_ex_result,
   output logic [DATA_W-1:0]     o_memory_data,
   output logic [DATA_W-1:0]     o_immediate,
   output logic [DATA_W-1:0]     o_in_port
);

   logic                  valid_q,   valid_d;
   logic [1:0]            sel_q,     sel_d;
   logic                  wb_q,      wb_d;
   logic [REG_ADDR_W-1:0] addr_q,    addr_d;
   logic [DATA_W-1:0]     ex_q,      ex_d;
   logic [DATA_W-1:0]     mem_q,     mem_d;
   logic [DATA_W-1:0]     imm_q,     imm_d;
   logic [DATA_W-1:0]     inport_q,  inport_d;

   // Next-state: flush clears to a bubble, stall holds, otherwise load
   always_comb begin
      valid_d  = valid_q;
      sel_d    = sel_q;
      wb_d     = wb_q;
      addr_d   = addr_q;
      ex_d     = ex_q;
      mem_d    = mem_q;
      imm_d    = imm_q;
      inport_d = inport_q;
      if (i_flush) begin
         valid_d  = 1'b0;
         sel_d    = WB_SEL_ALU;
         wb_d     = 1'b0;
         addr_d   = '0;
         ex_d     = '0;
         mem_d    = '0;
         imm_d    = '0;
         inport_d = '0;
      end else if (!i_stall) begin
         valid_d  = i_valid;
         sel_d    = i_wb_selector;
         wb_d     = i_write_back;
         addr_d   = i_write_addr;
         ex_d     = i_ex_result;
         mem_d    = i_memory_data;
         imm_d    = i_immediate;
         inport_d = i_in_port;
      end
   end

   // Buffer registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         valid_q  <= 1'b0;
         sel_q    <= WB_SEL_ALU;
         wb_q     <= 1'b0;
         addr_q   <= '0;
         ex_q     <= '0;
         mem_q    <= '0;
         imm_q    <= '0;
         inport_q <= '0;
      end else begin
         valid_q  <= valid_d;
         sel_q    <= sel_d;
         wb_q     <= wb_d;
         addr_q   <= addr_d;
         ex_q     <= ex_d;
         mem_q    <= mem_d;
         imm_q    <= imm_d;
         inport_q <= inport_d;
      end
   end

   assign o_valid       = valid_q;
   assign o_wb_selector = sel_q;
   assign o_write_back  = wb_q;
   assign o_write_addr  = addr_q;
   assign o_ex_result   = ex_q;
   assign o_memory_data = mem_q;
   assign o_immediate   = imm_q;
   assign o_in_port     = inport_q;

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Write-back stage: EXM/WB buffer, write-back source mux,
//               register-file write port, forwarding selects, registered
//               output port and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
   import pipeline_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic                  i_valid,
   input  logic [1:0]            i_wb_selector,
   input  logic                  i_write_back,
   input  logic [REG_ADDR_W-1:0] i_write_addr,
   input  logic [DATA_W-1:0]     i_ex_result,
   input  logic [DATA_W-1:0]     i_memory_data,
   input  logic [DATA_W-1:0]     i_immediate,
   input  logic [DATA_W-1:0]     i_in_port,
   input  logic                  i_output_port_en,
   input  logic [DATA_W-1:0]     i_output_data,
   input  logic [REG_ADDR_W-1:0] i_exm_rs,
   input  logic [REG_ADDR_W-1:0] i_exm_rd,
   output logic                  o_rf_write_en,
   output logic [REG_ADDR_W-1:0] o_rf_write_addr,
   output logic [DATA_W-1:0]     o_data_wb,
   output logic                  o_data1_forward,
   output logic                  o_data2_forward,
   output logic [DATA_W-1:0]     o_output_port,
   output logic [CNT_W-1:0]      o_retired_count
);

   logic                  w_buf_valid;
   logic [1:0]            w_buf_sel;
   logic                  w_buf_wb;
   logic [REG_ADDR_W-1:0] w_buf_addr;
   logic [DATA_W-1:0]     w_buf_ex;
   logic [DATA_W-1:0]     w_buf_mem;
   logic [DATA_W-1:0]     w_buf_imm;
   logic [DATA_W-1:0]     w_buf_inport;
   logic                  w_load;
   logic                  w_rf_we;

   logic [DATA_W-1:0]     out_port_q, out_port_d;
   logic [CNT_W-1:0]      count_q,    count_d;

   exm_wb_buffer #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_exm_wb_buffer (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .i_valid       (i_valid),
      .i_wb_selector (i_wb_selector),
      .i_write_back  (i_write_back),
      .i_write_addr  (i_write_addr),
      .i_ex_result   (i_ex_result),
      .i_memory_data (i_memory_data),
      .i_immediate   (i_immediate),
      .i_in_port     (i_in_port),
      .o_valid       (w_buf_valid),
      .o_wb_selector (w_buf_sel),
      .o_write_back  (w_buf_wb),
      .o_write_addr  (w_buf_addr),
      .o_ex_result   (w_buf_ex),
      .o_memory_data (w_buf_mem),
      .o_immediate   (w_buf_imm),
      .o_in_port     (w_buf_inport)
   );

   // The buffer advances only when neither flushed nor stalled
   assign w_load  = !i_flush && !i_stall;
   assign w_rf_we = w_buf_valid & w_buf_wb;

   // Write-back source mux
   always_comb begin
      o_data_wb = w_buf_ex;
      case (w_buf_sel)
         WB_SEL_ALU:    o_data_wb = w_buf_ex;
         WB_SEL_MEM:    o_data_wb = w_buf_mem;
         WB_SEL_IMM:    o_data_wb = w_buf_imm;
         WB_SEL_INPORT: o_data_wb = w_buf_inport;
         default:       o_data_wb = w_buf_ex;
      endcase
   end

   assign o_rf_write_en   = w_rf_we;
   assign o_rf_write_addr = w_buf_addr;
   assign o_data1_forward = w_rf_we && (w_buf_addr == i_exm_rs);
   assign o_data2_forward = w_rf_we && (w_buf_addr == i_exm_rd);

   // Output-port capture and retire counting; an instruction retires as it
   // leaves the buffer, so a stall cannot count it twice
   always_comb begin
      out_port_d = out_port_q;
      count_d    = count_q;
      if (w_load) begin
         if (i_valid && i_output_port_en) begin
            out_port_d = i_output_data;
         end
         if (w_buf_valid) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Output-port and counter registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         out_port_q <= '0;
         count_q    <= '0;
      end else begin
         out_port_q <= out_port_d;
         count_q    <= count_d;
      end
   end

   assign o_output_port   = out_port_q;
   assign o_retired_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage: directed scenarios plus
//               randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        stall, flush, valid, write_back, out_en;
   logic [1:0]  sel;
   logic [2:0]  waddr, exm_rs, exm_rd;
   logic [15:0] ex_res, mem_data, imm, in_port, out_data;

   logic        rf_we, fwd1, fwd2;
   logic [2:0]  rf_addr;
   logic [15:0] data_wb, out_port, retired;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state: what sits in the EXM/WB slot
   logic        m_valid, m_wb;
   logic [1:0]  m_sel;
   logic [2:0]  m_addr;
   logic [15:0] m_src[4];   // indexed by write-back selector
   logic [15:0] m_out;
   int unsigned m_cnt;

   wb_stage u_dut (
      .i_clk            (clk),
      .i_reset          (rst_n),
      .i_stall          (stall),
      .i_flush          (flush),
      .i_valid          (valid),
      .i_wb_selector    (sel),
      .i_write_back     (write_back),
      .i_write_addr     (waddr),
      .i_ex_result      (ex_res),
      .i_memory_data    (mem_data),
      .i_immediate      (imm),
      .i_in_port        (in_port),
      .i_output_port_en (out_en),
      .i_output_data    (out_data),
      .i_exm_rs         (exm_rs),
      .i_exm_rd         (exm_rd),
      .o_rf_write_en    (rf_we),
      .o_rf_write_addr  (rf_addr),
      .o_data_wb        (data_wb),
      .o_data1_forward  (fwd1),
      .o_data2_forward  (fwd2),
      .o_output_port    (out_port),
      .o_retired_count  (retired)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      logic we_exp;
      we_exp = m_valid && m_wb;
      check({tag, ":rf_we"},   32'(rf_we),    32'(we_exp));
      check({tag, ":rf_addr"}, 32'(rf_addr),  32'(m_addr));
      check({tag, ":data_wb"}, 32'(data_wb),  32'(m_src[m_sel]));
      check({tag, ":fwd1"},    32'(fwd1),     32'(we_exp && (m_addr == exm_rs)));
      check({tag, ":fwd2"},    32'(fwd2),     32'(we_exp && (m_addr == exm_rd)));
      check({tag, ":outport"}, 32'(out_port), 32'(m_out));
      check({tag, ":retired"}, 32'(retired),  32'(m_cnt));
   endtask

   // Advance the model by one edge using the currently driven inputs, then
   // clock the DUT and optionally compare everything
   task automatic step(input string tag, input bit do_check);
      if (!rst_n) begin
         m_valid = 0; m_wb = 0; m_sel = 0; m_addr = 0;
         m_src = '{16'h0, 16'h0, 16'h0, 16'h0};
         m_out = 0; m_cnt = 0;
      end else if (flush) begin
         m_valid = 0; m_wb = 0; m_sel = 0; m_addr = 0;
         m_src = '{16'h0, 16'h0, 16'h0, 16'h0};
      end else if (!stall) begin
         if (m_valid) m_cnt = (m_cnt + 1) % 65536;
         if (valid && out_en) m_out = out_data;
         m_valid = valid; m_wb = write_back; m_sel = sel; m_addr = waddr;
         m_src = '{ex_res, mem_data, imm, in_port};
      end
      @(posedge clk);
      #1;
      if (do_check) check_all(tag);
   endtask

   task automatic set_insn(input logic v, input logic wb, input logic [1:0] s,
                           input logic [2:0] a, input logic [15:0] d);
      valid = v; write_back = wb; sel = s; waddr = a; ex_res = d;
   endtask

   initial begin
      logic [15:0] sweep_exp[4];
      int guard;
      sweep_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

      // Reset asserted with a live instruction on the inputs
      rst_n = 0; stall = 0; flush = 0; out_en = 1; out_data = 16'hBEEF;
      set_insn(1, 1, 2'b00, 3'd4, 16'h5A5A);
      mem_data = 16'h0; imm = 16'h0; in_port = 16'h0;
      exm_rs = 3'd4; exm_rd = 3'd4;
      step("reset0", 1);
      step("reset1", 1);
      rst_n = 1; out_en = 0;

      // Write-back mux sweep
      ex_res = 16'h1111; mem_data = 16'h2222; imm = 16'h3333; in_port = 16'h4444;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s); valid = 1; write_back = 1; waddr = 3'd1;
         step("mux", 1);
         check("mux_const", 32'(data_wb), 32'(sweep_exp[s]));
      end

      // Forwarding
      set_insn(1, 1, 2'b00, 3'd3, 16'h0033);
      exm_rs = 3'd3; exm_rd = 3'd5;
      step("fwd_rs", 1);
      check("fwd_rs_d1", 32'(fwd1), 32'd1);
      check("fwd_rs_d2", 32'(fwd2), 32'd0);
      exm_rd = 3'd3;
      #1;
      check_all("fwd_both");
      check("fwd_both_d2", 32'(fwd2), 32'd1);
      write_back = 0;
      step("fwd_nowb", 1);
      check("fwd_nowb_d1", 32'(fwd1), 32'd0);

      // Stall holds the slot and the instruction retires once
      set_insn(1, 1, 2'b00, 3'd2, 16'hABCD);
      step("stall_load", 1);
      set_insn(1, 1, 2'b01, 3'd6, 16'h9999);
      stall = 1;
      for (int i = 0; i < 3; i++) step("stall_hold", 1);
      check("stall_data", 32'(data_wb), 32'h0000ABCD);
      flush = 1;
      step("stall_flush", 1);
      check("flush_we", 32'(rf_we), 32'd0);
      stall = 0; flush = 0;
      step("post_flush", 1);

      // Output port capture, hold, and flush suppression
      set_insn(1, 0, 2'b00, 3'd0, 16'h0);
      out_en = 1; out_data = 16'h00FF;
      step("out_load", 1);
      check("out_val", 32'(out_port), 32'h000000FF);
      out_en = 0; out_data = 16'h7777;
      step("out_hold", 1);
      out_en = 1; out_data = 16'h1234; flush = 1;
      step("out_flush", 1);
      check("out_flush_val", 32'(out_port), 32'h000000FF);
      flush = 0; out_en = 0;

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst_n      = ($urandom_range(0, 63) != 0);
         stall      = ($urandom_range(0, 3) == 0);
         flush      = ($urandom_range(0, 7) == 0);
         valid      = ($urandom_range(0, 3) != 0);
         write_back = $urandom_range(0, 1);
         sel        = 2'($urandom_range(0, 3));
         waddr      = 3'($urandom_range(0, 7));
         ex_res     = 16'($urandom);
         mem_data   = 16'($urandom);
         imm        = 16'($urandom);
         in_port    = 16'($urandom);
         out_en     = ($urandom_range(0, 3) == 0);
         out_data   = 16'($urandom);
         exm_rs     = 3'($urandom_range(0, 7));
         exm_rd     = 3'($urandom_range(0, 7));
         step("rand", 1);
      end

      // Drive the counter to all-ones, then one more retire wraps it
      rst_n = 1; stall = 0; flush = 0; out_en = 0;
      set_insn(1, 1, 2'b00, 3'd7, 16'h0);
      step("wrap_prime", 1);
      guard = 0;
      while (m_cnt != 32'hFFFF && guard < 70000) begin
         step("wrap_run", 0);
         guard++;
      end
      check("wrap_at_max", 32'(retired), 32'h0000FFFF);
      step("wrap", 1);
      check("wrap_zero", 32'(retired), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage, directly downstream of the execute-memory stage.
- Registers the execute-memory results into an EXM/WB buffer.
- Selects the write-back value and drives the register-file write port.
- Generates the two forwarding selects fed back to execute-memory, holds the registered output port, and counts retired instructions.

Parameters:
DATA_W, 16, datapath width
REG_ADDR_W, 3, register-file address width
CNT_W, 16, retired-instruction counter width

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  synchronous, active-low reset
i_stall  input  1  hold EXM/WB buffer contents
i_flush  input  1  insert bubble into EXM/WB buffer
i_valid  input  1  execute-memory slot holds a real instruction
i_wb_selector  input  2  write-back source select
i_write_back  input  1  instruction writes the register file
i_write_addr  input  REG_ADDR_W  destination register
i_ex_result  input  DATA_W  ALU/mov result
i_memory_data  input  DATA_W  data-memory read data
i_immediate  input  DATA_W  immediate from decode
i_in_port  input  DATA_W  external input port
i_output_port_en  input  1  OUT instruction in execute-memory
i_output_data  input  DATA_W  forwarded data1 value for OUT
i_exm_rs  input  REG_ADDR_W  source register of the instruction now in execute-memory (data1)
i_exm_rd  input  REG_ADDR_W  second operand register of that instruction (data2)
o_rf_write_en  output  1  register-file write enable
o_rf_write_addr  output  REG_ADDR_W  register-file write address
o_data_wb  output  DATA_W  selected write-back data, to register file and to execute-memory i_data_wb
o_data1_forward  output  1  forward select for data1
o_data2_forward  output  1  forward select for data2
o_output_port  output  DATA_W  registered output port
o_retired_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset (i_reset==0 at a rising edge):
  - Buffer cleared: valid=0, write_back=0, addr=0, all data fields 0.
  - o_output_port=0, o_retired_count=0.
  - Therefore o_rf_write_en=0, both forward selects 0, o_data_wb=0 (selector 00, ex_result 0).
  - Reset overrides stall and flush.
- Buffer update at each rising edge, priority reset > flush > stall > load:
  - flush: valid=0 and write_back=0; other fields don't-care, cleared to 0.
  - stall without flush: all fields hold.
  - load: capture i_valid, i_wb_selector, i_write_back, i_write_addr, i_ex_result, i_memory_data, i_immediate, i_in_port.
  - Latency: one cycle from execute-memory outputs to buffer.
- Write-back mux, combinational from buffer:
  - 00 ex_result
  - 01 memory_data
  - 10 immediate
  - 11 in_port (value sampled at load)
- o_rf_write_en = buf_valid & buf_write_back. o_rf_write_addr = buf_addr.
- Forwarding, combinational:
  - o_data1_forward = o_rf_write_en & (buf_addr == i_exm_rs).
  - o_data2_forward = o_rf_write_en & (buf_addr == i_exm_rd).
  - Both may assert together.
  - Register 0 is not special.
- Output port:
  - On a load edge with i_valid & i_output_port_en, o_output_port <= i_output_data.
  - Otherwise it holds; never tri-stated.
  - Flush or stall on that edge suppresses the update.
- Retired counter:
  - Increments by 1 on each edge where the buffer is loaded (not flushed, not stalled) and the outgoing buffer valid is 1.
  - Wraps from all-ones to 0.
  - A stall keeps the current instruction from counting twice.

Decomposition:
- Shared package pipeline_pkg holds:
  - WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_IMM=2'b10, WB_SEL_INPORT=2'b11.
  - Default widths.
- One sub-module, exm_wb_buffer: parameterised pipeline register with stall/flush and synchronous active-low reset.
- Mux, forwarding compare, output-port register and counter stay in wb_stage.

Test Plan:
- Reset: hold i_reset=0 for 2 cycles with i_valid=1, i_write_back=1 -> o_rf_write_en=0, o_output_port=0, o_retired_count=0, forwards 0.
- Mux sweep: load ex_result=16'h1111, memory_data=16'h2222, immediate=16'h3333, in_port=16'h4444 with selector 00..11 -> o_data_wb is 1111, 2222, 3333, 4444 the cycle after each load.
- Forwarding: load write_addr=3, write_back=1, then i_exm_rs=3, i_exm_rd=5 -> data1_forward=1, data2_forward=0; rd=3 -> both 1; write_back=0 -> both 0.
- Stall/flush: load addr=2, data=16'hABCD, stall 3 cycles -> outputs constant, counter +1 only once; flush together with stall -> o_rf_write_en=0 next cycle.
- Output port: OUT with i_output_data=16'h00FF -> o_output_port=00FF after edge and held; OUT during flush -> unchanged.
- Counter wrap: preload path to 16'hFFFF via valid loads, one more valid retire -> o_retired_count=0.
